// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage: owns the PC, issues one outstanding I-memory request at a time
// and fills the IF/ID register. Define IF_MISALIGN_TRAP_EN to trap misaligned redirect targets.
module instr_fetch_stage #(
    parameter int                    inst_width = 32,
    parameter logic [inst_width-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  imem_req_valid,
    output logic [inst_width-1:0] imem_req_addr,
    input  logic                  imem_req_ready,
    input  logic                  imem_rsp_valid,
    input  logic [inst_width-1:0] imem_rsp_data,
    input  logic                  stall,
    input  logic                  redirect_valid,
    input  logic [inst_width-1:0] redirect_pc,
    output logic                  if_id_valid,
    output logic [inst_width-1:0] if_id_pc,
    output logic [inst_width-1:0] if_id_instr,
    output logic [inst_width-1:0] if_id_pc_plus4
`ifdef IF_MISALIGN_TRAP_EN
    ,
    output logic                  if_misalign
`endif
);

    localparam logic [inst_width-1:0] C_FOUR       = inst_width'(4);
    localparam logic [inst_width-1:0] C_ALIGN_MASK = ~inst_width'(3);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t                r_state, w_state_next;
    logic [inst_width-1:0] r_pc, r_req_pc, r_skid_pc, r_skid_instr;
    logic                  r_drop;
    logic                  r_if_id_valid;
    logic [inst_width-1:0] r_if_id_pc, r_if_id_instr, r_if_id_pc_plus4;

    logic                  w_req_fire, w_load, w_skid_wr, w_drop_next;
    logic                  w_misalign, w_trap_idle, w_trap_load;
    logic [inst_width-1:0] w_load_pc, w_load_instr, w_trap_instr;

    // Requests are held off while a flushed response is still owed by memory.
    assign imem_req_valid = rst_n && (r_state == S_REQ) && !r_drop;
    assign imem_req_addr  = r_pc;
    assign w_req_fire     = imem_req_valid && imem_req_ready;
    assign w_drop_next    = w_req_fire || (!imem_rsp_valid && ((r_state == S_WAIT) || r_drop));

    assign if_id_valid    = r_if_id_valid;
    assign if_id_pc       = r_if_id_pc;
    assign if_id_instr    = r_if_id_instr;
    assign if_id_pc_plus4 = r_if_id_pc_plus4;

`ifdef IF_MISALIGN_TRAP_EN
    logic r_trap_idle, r_trap_load, r_misalign;

    assign w_misalign   = redirect_valid && (redirect_pc[1:0] != 2'b00);
    assign w_trap_idle  = r_trap_idle;
    assign w_trap_load  = r_trap_load;
    assign w_trap_instr = inst_width'(32'h0000_0013);
    assign if_misalign  = r_misalign;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_trap_idle <= 1'b0;
            r_trap_load <= 1'b0;
            r_misalign  <= 1'b0;
        end else if (redirect_valid) begin
            r_trap_idle <= w_misalign;
            r_trap_load <= w_misalign;
            r_misalign  <= 1'b0;
        end else begin
            r_trap_load <= 1'b0;
            if (w_load)
                r_misalign <= w_trap_load;
            else if (!stall)
                r_misalign <= 1'b0;
        end
    end
`else
    assign w_misalign   = 1'b0;
    assign w_trap_idle  = 1'b0;
    assign w_trap_load  = 1'b0;
    assign w_trap_instr = '0;
`endif

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_skid_wr    = 1'b0;
        w_load_pc    = r_req_pc;
        w_load_instr = imem_rsp_data;
        if (redirect_valid) begin
            w_state_next = w_misalign ? S_HOLD : S_REQ;
        end else begin
            case (r_state)
                S_REQ: begin
                    if (w_req_fire)
                        w_state_next = S_WAIT;
                end
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        if (!stall || !r_if_id_valid) begin
                            w_load       = 1'b1;
                            w_state_next = S_REQ;
                        end else begin
                            w_skid_wr    = 1'b1;
                            w_state_next = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    w_load_pc    = r_skid_pc;
                    w_load_instr = r_skid_instr;
                    // A pending trap word is delivered once, then fetch parks here.
                    if (w_trap_load) begin
                        w_load = 1'b1;
                    end else if (!w_trap_idle && !stall) begin
                        w_load       = 1'b1;
                        w_state_next = S_REQ;
                    end
                end
                default: w_state_next = S_REQ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= S_REQ;
            r_pc             <= RESET_PC;
            r_req_pc         <= '0;
            r_drop           <= 1'b0;
            r_skid_pc        <= '0;
            r_skid_instr     <= '0;
            r_if_id_valid    <= 1'b0;
            r_if_id_pc       <= '0;
            r_if_id_instr    <= '0;
            r_if_id_pc_plus4 <= '0;
        end else begin
            r_state <= w_state_next;
            if (redirect_valid) begin
                r_pc          <= redirect_pc & C_ALIGN_MASK;
                r_drop        <= w_drop_next;
                r_if_id_valid <= 1'b0;
                r_skid_pc     <= w_misalign ? redirect_pc : '0;
                r_skid_instr  <= w_misalign ? w_trap_instr : '0;
            end else begin
                if (w_req_fire) begin
                    r_pc     <= r_pc + C_FOUR;
                    r_req_pc <= r_pc;
                end
                if (imem_rsp_valid)
                    r_drop <= 1'b0;
                if (w_skid_wr) begin
                    r_skid_pc    <= r_req_pc;
                    r_skid_instr <= imem_rsp_data;
                end
                if (w_load) begin
                    r_if_id_valid    <= 1'b1;
                    r_if_id_pc       <= w_load_pc;
                    r_if_id_instr    <= w_load_instr;
                    r_if_id_pc_plus4 <= w_load_pc + C_FOUR;
                end else if (!stall) begin
                    r_if_id_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Scoreboard bench for instr_fetch_stage: a behavioural memory answers each accepted request,
// expected IF/ID words are queued on acceptance and compared when decode consumes them.
module tb_instr_fetch_stage;

    localparam logic [31:0] KEY = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc_plus4;
`ifdef IF_MISALIGN_TRAP_EN
    logic        if_misalign;
`endif

    always #5 clk = ~clk;

    instr_fetch_stage #(.inst_width(32), .RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_id_valid    (if_id_valid),
        .if_id_pc       (if_id_pc),
        .if_id_instr    (if_id_instr),
        .if_id_pc_plus4 (if_id_pc_plus4)
`ifdef IF_MISALIGN_TRAP_EN
        ,
        .if_misalign    (if_misalign)
`endif
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_issued = 0;
    logic [95:0] sb_q[$];
    logic [31:0] exp_pc;

    logic        c_stall, c_ready, c_redirect;
    logic [31:0] c_redirect_pc;
    int          rsp_lat;
    logic        mem_busy;
    int          mem_cnt;
    logic [31:0] mem_addr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Called at a falling edge: drive this cycle's inputs and account for the coming rising edge.
    task automatic drive_and_eval();
        logic [95:0] e;
        if (mem_busy && mem_cnt == 1) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_addr ^ KEY;
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        stall          = c_stall;
        imem_req_ready = c_ready;
        redirect_valid = c_redirect;
        redirect_pc    = c_redirect_pc;

        if (if_id_valid && !stall) begin
            if (sb_q.size() == 0) begin
                check("if_id_unexpected", 32'(sb_q.size() != 0), 32'd1);
            end else begin
                e = sb_q.pop_front();
                check("if_id_pc", if_id_pc, e[95:64]);
                check("if_id_instr", if_id_instr, e[63:32]);
                check("if_id_pc_plus4", if_id_pc_plus4, e[31:0]);
                n_issued++;
                $display("issue #%0d pc=%h instr=%h pc4=%h", n_issued, if_id_pc, if_id_instr, if_id_pc_plus4);
            end
        end
        if (redirect_valid) begin
            sb_q.delete();
            exp_pc = redirect_pc & 32'hFFFF_FFFC;
        end else if (imem_req_valid && imem_req_ready) begin
            check("req_addr", imem_req_addr, exp_pc);
            sb_q.push_back({exp_pc, exp_pc ^ KEY, exp_pc + 32'd4});
            exp_pc = exp_pc + 32'd4;
        end

        if (mem_busy && mem_cnt == 1)
            mem_busy = 1'b0;
        else if (mem_busy)
            mem_cnt--;
        if (imem_req_valid && imem_req_ready) begin
            mem_busy = 1'b1;
            mem_cnt  = rsp_lat;
            mem_addr = imem_req_addr;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        drive_and_eval();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        found;
        logic [31:0] snap_pc, snap_instr, snap_addr;

        rst_n = 1'b0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        c_stall = 1'b0; c_ready = 1'b1; c_redirect = 1'b0; c_redirect_pc = '0;
        rsp_lat = 1; mem_busy = 1'b0; mem_cnt = 0; mem_addr = '0;
        exp_pc = 32'h0000_0000;

        repeat (3) @(negedge clk);
        check("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        check("rst_if_id_valid", {31'd0, if_id_valid}, 32'd0);
        check("rst_if_id_pc", if_id_pc, 32'd0);
        check("rst_if_id_instr", if_id_instr, 32'd0);
        check("rst_if_id_pc_plus4", if_id_pc_plus4, 32'd0);
`ifdef IF_MISALIGN_TRAP_EN
        check("rst_if_misalign", {31'd0, if_misalign}, 32'd0);
`endif
        #2 rst_n = 1'b1;

        // Sequential fetch with a zero-wait memory.
        cycle();
        check("first_req_valid", {31'd0, imem_req_valid}, 32'd1);
        check("first_req_addr", imem_req_addr, 32'h0000_0000);
        run(9);

        // Decode stall while a response arrives: hold, then skid delivery.
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (if_id_valid) begin found = 1'b1; break; end
            drive_and_eval();
        end
        check("stall_find_valid", {31'd0, found}, 32'd1);
        snap_pc = if_id_pc; snap_instr = if_id_instr;
        c_stall = 1'b1;
        drive_and_eval();
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("stall_hold_valid", {31'd0, if_id_valid}, 32'd1);
            check("stall_hold_pc", if_id_pc, snap_pc);
            check("stall_hold_instr", if_id_instr, snap_instr);
            check("stall_no_req", {31'd0, imem_req_valid}, 32'd0);
        end
        c_stall = 1'b0;
        cycle();
        check("unstall_no_req", {31'd0, imem_req_valid}, 32'd0);
        cycle();
        check("unstall_skid_valid", {31'd0, if_id_valid}, 32'd1);
        check("unstall_resume_req", {31'd0, imem_req_valid}, 32'd1);
        run(6);

        // Redirect while a slow request is in flight: its response is dropped.
        rsp_lat = 3;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_busy && mem_cnt == 3) begin found = 1'b1; break; end
            drive_and_eval();
        end
        check("wait_find", {31'd0, found}, 32'd1);
        c_redirect = 1'b1; c_redirect_pc = 32'h0000_0100;
        drive_and_eval();
        c_redirect = 1'b0;
        cycle();
        check("redir_if_id_flushed", {31'd0, if_id_valid}, 32'd0);
        check("redir_drop_no_req1", {31'd0, imem_req_valid}, 32'd0);
        cycle();
        check("redir_drop_no_req2", {31'd0, imem_req_valid}, 32'd0);
        cycle();
        check("redir_target_req", {31'd0, imem_req_valid}, 32'd1);
        check("redir_target_addr", imem_req_addr, 32'h0000_0100);
        run(10);
        rsp_lat = 1;
        run(4);

        // Redirect, stall and a response all in one cycle: flush wins.
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_busy && mem_cnt == 1) begin found = 1'b1; break; end
            drive_and_eval();
        end
        check("rsp_find", {31'd0, found}, 32'd1);
        c_stall = 1'b1; c_redirect = 1'b1; c_redirect_pc = 32'h0000_0200;
        drive_and_eval();
        c_stall = 1'b0; c_redirect = 1'b0;
        cycle();
        check("flush_if_id_valid", {31'd0, if_id_valid}, 32'd0);
        check("flush_req_valid", {31'd0, imem_req_valid}, 32'd1);
        check("flush_req_addr", imem_req_addr, 32'h0000_0200);
        run(6);

        // Memory back-pressure: request stays up with a stable address.
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (imem_req_valid) begin found = 1'b1; break; end
            drive_and_eval();
        end
        check("bp_find", {31'd0, found}, 32'd1);
        snap_addr = imem_req_addr;
        c_ready = 1'b0;
        drive_and_eval();
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("bp_req_valid", {31'd0, imem_req_valid}, 32'd1);
            check("bp_req_addr", imem_req_addr, snap_addr);
        end
        c_ready = 1'b1;
        run(4);

        // PC wrap at the top of the address space.
        c_redirect = 1'b1; c_redirect_pc = 32'hFFFF_FFFC;
        cycle();
        c_redirect = 1'b0;
        run(10);

        // Misaligned redirect target.
`ifdef IF_MISALIGN_TRAP_EN
        c_stall = 1'b1; c_redirect = 1'b1; c_redirect_pc = 32'h0000_0102;
        cycle();
        c_redirect = 1'b0;
        cycle();
        cycle();
        check("trap_if_id_valid", {31'd0, if_id_valid}, 32'd1);
        check("trap_misalign", {31'd0, if_misalign}, 32'd1);
        check("trap_pc", if_id_pc, 32'h0000_0102);
        check("trap_instr", if_id_instr, 32'h0000_0013);
        cycle();
        check("trap_no_req", {31'd0, imem_req_valid}, 32'd0);
        c_redirect = 1'b1; c_redirect_pc = 32'h0000_0300;
        cycle();
        c_redirect = 1'b0; c_stall = 1'b0;
        run(8);
`else
        c_redirect = 1'b1; c_redirect_pc = 32'h0000_0102;
        cycle();
        c_redirect = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (imem_req_valid) begin found = 1'b1; break; end
            drive_and_eval();
        end
        check("misalign_find_req", {31'd0, found}, 32'd1);
        check("misalign_masked_addr", imem_req_addr, 32'h0000_0100);
        drive_and_eval();
        run(6);
`endif

        // Drain: stop issuing and let every queued word reach decode.
        c_ready = 1'b0;
        run(6);
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch_stage.md
Name: instr_fetch_stage

Overview:
- Fetch stage directly upstream of the decode-stage immediate generator.
- Owns the PC and issues single-outstanding requests to instruction memory.
- Captures returned words into the IF/ID pipeline register (pc, instr, pc+4), which feeds decode.
- Supports decode stall, and execute-stage redirect/flush for taken branches, JAL and JALR.

Parameters:
- inst_width, 32, width of instruction word, PC and memory address.
- RESET_PC, 32'h0000_0000, PC loaded on reset.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_addr  out  inst_width  byte address of fetch (word aligned).
- imem_req_ready  in  1  memory accepts request this cycle.
- imem_rsp_valid  in  1  response word valid (one cycle pulse per accepted request).
- imem_rsp_data  in  inst_width  instruction word.
- stall  in  1  decode cannot accept; hold IF/ID contents.
- redirect_valid  in  1  flush and restart fetch at redirect_pc.
- redirect_pc  in  inst_width  new PC (branch/JAL/JALR target).
- if_id_valid  out  1  IF/ID register holds a live instruction.
- if_id_pc  out  inst_width  PC of held instruction.
- if_id_instr  out  inst_width  held instruction, decoded by immediate generator.
- if_id_pc_plus4  out  inst_width  if_id_pc + 4, link value for JAL/JALR.

Behaviour:
- Reset (async on rst_n low):
  - pc = RESET_PC; state = S_REQ.
  - imem_req_valid = 0 while rst_n is low.
  - if_id_valid = 0; if_id_pc / if_id_instr / if_id_pc_plus4 = 0.
  - Skid buffer empty; drop flag = 0.
- FSM states:
  - S_REQ: imem_req_valid = 1, imem_req_addr = pc. On imem_req_ready -> S_WAIT; pc <= pc + 4, wrapping modulo 2^inst_width.
  - S_WAIT: imem_req_valid = 0. On imem_rsp_valid:
    - if !stall or !if_id_valid, load IF/ID with {pc_of_req, data, pc_of_req+4}, set if_id_valid = 1, go to S_REQ;
    - else store in skid buffer and go to S_HOLD.
  - S_HOLD: imem_req_valid = 0. On the first cycle with stall = 0, skid moves to IF/ID and state goes to S_REQ.
- IF/ID with no new word:
  - With stall = 1: IF/ID holds all fields unchanged.
  - With stall = 0 and no new word: if_id_valid <= 0.
- Request address:
  - The address of the outstanding request is registered separately (req_pc), so if_id_pc is always the address actually fetched.
  - Sequential throughput is one instruction per two cycles minimum (single outstanding); a zero-wait memory gives REQ, WAIT, REQ, ...
- Redirect (highest priority, beats stall and responses in the same cycle):
  - pc <= {redirect_pc[inst_width-1:2], 2'b00}; if_id_valid <= 0; skid cleared; state <= S_REQ.
  - If a request is in flight (S_WAIT), set the drop flag. The next imem_rsp_valid is discarded and clears the flag; no new request is issued until it clears.
  - A redirect in S_REQ in the same cycle as imem_req_ready: the accepted request is treated as in flight and dropped.
  - Redirect and imem_rsp_valid in the same cycle: the response is discarded and the drop flag is not set.
- Reset mid-transaction: all state cleared immediately. Memory is reset by the same rst_n, so no stale response is expected.

Optional Feature:
- Macro IF_MISALIGN_TRAP_EN.
- Defined:
  - Adds output if_misalign (1 bit, reset 0).
  - A redirect_pc with bits [1:0] != 0 issues no memory request. The next cycle loads IF/ID with if_id_pc = redirect_pc (unmasked), if_id_instr = 32'h0000_0013 (NOP), if_misalign = 1, if_id_valid = 1.
  - Fetch then idles in S_HOLD until the next redirect.
- Not defined: low two bits of redirect_pc are silently masked to 00; no if_misalign port.

Test Plan:
- Reset release, imem ready always, rsp one cycle after accept with data = addr ^ 32'hA5A5_0000 -> requests to 0x0, 0x4, 0x8; IF/ID shows pc 0x0/instr 0xA5A5_0000, pc_plus4 0x4, in order.
- stall = 1 for 5 cycles while if_id_valid = 1 and a response arrives -> IF/ID unchanged, no new request, skid word delivered the first cycle after stall drops, then fetch resumes at next pc.
- redirect_valid with redirect_pc = 0x100 while in S_WAIT -> that response is dropped, if_id_valid = 0, next request address 0x100.
- redirect in the same cycle as stall = 1 and imem_rsp_valid = 1 -> flush wins, response discarded, next request to target.
- imem_req_ready held low 4 cycles -> imem_req_valid stays 1 with stable address; pc at 0xFFFF_FFFC wraps to 0x0000_0000 next.
- With IF_MISALIGN_TRAP_EN, redirect_pc = 0x102 -> no request, if_misalign = 1, if_id_instr = 0x0000_0013, if_id_pc = 0x102. Without the macro -> request to 0x100.
